// File: rtl/alu_mdu.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide,
// one FIX cycle for sign correction and divide special cases, valid/ready on both sides.
module alu_mdu #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [TAG_W-1:0] r_tag;
    logic [XLEN-1:0]  r_result;
    logic [2:0]       r_op;
    logic             r_neg;
    logic             r_rneg;
    logic             r_ovf;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_opb;

    logic             w_accept;
    logic             w_a_sgn;
    logic             w_b_sgn;
    logic             w_ovf;
    logic [XLEN-1:0]  w_a_mag;
    logic [XLEN-1:0]  w_b_mag;
    logic [XLEN:0]    w_sum;
    logic [XLEN:0]    w_shift;
    logic [XLEN:0]    w_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]  w_quo;
    logic [XLEN-1:0]  w_rem;
    logic             w_divz;
    logic [XLEN-1:0]  w_res;

    assign in_ready   = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign out_valid  = (r_state == DONE);
    assign out_result = r_result;
    assign out_tag    = r_tag;
    assign w_accept   = in_valid & in_ready & ~flush;

    // Signedness per op: MULH/DIV/REM both signed, MULHSU only rs1
    assign w_a_sgn = in_a[XLEN-1] & ((in_op == 3'd1) | (in_op == 3'd2) | (in_op == 3'd4) | (in_op == 3'd6));
    assign w_b_sgn = in_b[XLEN-1] & ((in_op == 3'd1) | (in_op == 3'd4) | (in_op == 3'd6));
    assign w_a_mag = w_a_sgn ? -in_a : in_a;
    assign w_b_mag = w_b_sgn ? -in_b : in_b;
    assign w_ovf   = ((in_op == 3'd4) | (in_op == 3'd6)) & (in_a == {1'b1, {(XLEN-1){1'b0}}}) & (&in_b);

    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_opb};

    assign w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quo  = r_neg ? -r_lo : r_lo;
    // With a zero divisor the remainder magnitude is |rs1|; re-signing restores rs1
    assign w_rem  = r_rneg ? -r_hi : r_hi;
    assign w_divz = (r_opb == '0);

    always_comb begin
        w_res = '0;
        case (r_op)
            3'd0:                w_res = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    w_res = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:          w_res = w_divz ? {XLEN{1'b1}} : (r_ovf ? {1'b1, {(XLEN-1){1'b0}}} : w_quo);
            default:             w_res = r_ovf ? '0 : w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_tag    <= '0;
            r_result <= '0;
        end else if (flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_state <= BUSY;
                    r_cnt   <= '0;
                    r_tag   <= in_tag;
                end
                BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(XLEN-1)) begin
                        r_state <= FIX;
                        r_cnt   <= '0;
                    end
                end
                FIX: begin
                    r_result <= w_res;
                    r_state  <= DONE;
                end
                default: if (w_accept) begin
                    r_state <= BUSY;
                    r_cnt   <= '0;
                    r_tag   <= in_tag;
                end else if (out_ready) begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Datapath: operands loaded at accept, one radix-2 step per BUSY cycle
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op   <= in_op;
            r_neg  <= w_a_sgn ^ w_b_sgn;
            r_rneg <= w_a_sgn;
            r_ovf  <= w_ovf;
            r_hi   <= '0;
            r_lo   <= in_op[2] ? w_a_mag : w_b_mag;
            r_opb  <= in_op[2] ? w_b_mag : w_a_mag;
        end else if (r_state == BUSY) begin
            if (r_op[2]) begin
                if (!w_diff[XLEN])
                    {r_hi, r_lo} <= {w_diff[XLEN-1:0], r_lo[XLEN-2:0], 1'b1};
                else
                    {r_hi, r_lo} <= {w_shift[XLEN-1:0], r_lo[XLEN-2:0], 1'b0};
            end else begin
                {r_hi, r_lo} <= {w_sum, r_lo[XLEN-1:1]};
            end
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Directed and random checks of alu_mdu at XLEN=8 and XLEN=32.
module tb_alu_mdu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic       a_vld = 1'b0, a_ordy = 1'b0;
    logic [2:0] a_op = '0;
    logic [7:0] a_a = '0, a_b = '0;
    logic [3:0] a_tag = '0;
    logic       a_rdy, a_ovld;
    logic [7:0] a_res;
    logic [3:0] a_otag;

    logic        b_vld = 1'b0, b_ordy = 1'b0;
    logic [2:0]  b_op = '0;
    logic [31:0] b_a = '0, b_b = '0;
    logic [3:0]  b_tag = '0;
    logic        b_rdy, b_ovld;
    logic [31:0] b_res;
    logic [3:0]  b_otag;

    alu_mdu #(.XLEN(8), .TAG_W(4)) dut8 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(a_vld), .in_ready(a_rdy), .in_op(a_op), .in_a(a_a), .in_b(a_b), .in_tag(a_tag),
        .out_valid(a_ovld), .out_ready(a_ordy), .out_result(a_res), .out_tag(a_otag)
    );

    alu_mdu #(.XLEN(32), .TAG_W(4)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(b_vld), .in_ready(b_rdy), .in_op(b_op), .in_a(b_a), .in_b(b_b), .in_tag(b_tag),
        .out_valid(b_ovld), .out_ready(b_ordy), .out_result(b_res), .out_tag(b_otag)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        longint sa, sb, p;
        sa = (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6) ? longint'($signed(a)) : longint'(a);
        sb = (op == 3'd1 || op == 3'd4 || op == 3'd6) ? longint'($signed(b)) : longint'(b);
        p = 0;
        case (op)
            3'd0: begin p = sa * sb; return p[7:0]; end
            3'd1, 3'd2, 3'd3: begin p = sa * sb; return p[15:8]; end
            3'd4, 3'd5: begin
                if (b == 8'h00) return 8'hFF;
                if (op == 3'd4 && a == 8'h80 && b == 8'hFF) return 8'h80;
                p = sa / sb;
                return p[7:0];
            end
            default: begin
                if (b == 8'h00) return a;
                if (op == 3'd6 && a == 8'h80 && b == 8'hFF) return 8'h00;
                p = sa % sb;
                return p[7:0];
            end
        endcase
    endfunction

    // Issue one op on the 8-bit unit, check latency, stall, then check result/tag and consume
    task automatic op8(input string nm, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] t, input logic [7:0] exp, input int stall);
        int n;
        @(negedge clk);
        a_vld = 1'b1; a_op = op; a_a = a; a_b = b; a_tag = t;
        @(posedge clk); #1;
        a_vld = 1'b0;
        n = 0;
        while (!a_ovld && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk_eq({nm, "_lat"}, 64'(n), 64'd9);
        repeat (stall) @(posedge clk);
        #1;
        chk_eq(nm, 64'(a_res), 64'(exp));
        chk_eq({nm, "_tag"}, 64'(a_otag), 64'(t));
        @(negedge clk);
        a_ordy = 1'b1;
        @(posedge clk); #1;
        a_ordy = 1'b0;
    endtask

    task automatic wait32(input string nm, output int n);
        n = 0;
        while (!b_ovld && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk_eq({nm, "_lat"}, 64'(n), 64'd33);
    endtask

    initial begin
        int n;
        logic seen;
        logic [2:0] rop;
        logic [7:0] ra, rb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_eq("rst_ovld8", 64'(a_ovld), 64'd0);
        chk_eq("rst_res8", 64'(a_res), 64'd0);
        chk_eq("rst_tag8", 64'(a_otag), 64'd0);
        chk_eq("rst_rdy8", 64'(a_rdy), 64'd1);
        chk_eq("rst_ovld32", 64'(b_ovld), 64'd0);
        chk_eq("rst_rdy32", 64'(b_rdy), 64'd1);

        op8("mul",     3'd0, 8'hFD, 8'h05, 4'd1, 8'hF1, 0);
        op8("mulh",    3'd1, 8'hFD, 8'h05, 4'd2, 8'hFF, 0);
        op8("mulhu",   3'd3, 8'hFF, 8'hFF, 4'd3, 8'hFE, 0);
        op8("mulhsu",  3'd2, 8'hFF, 8'hFF, 4'd4, 8'hFF, 0);
        op8("mulhu80", 3'd3, 8'h80, 8'h80, 4'd5, 8'h40, 0);
        op8("div",     3'd4, 8'hF9, 8'h02, 4'd6, 8'hFD, 0);
        op8("rem",     3'd6, 8'hF9, 8'h02, 4'd7, 8'hFF, 0);
        op8("divu",    3'd5, 8'hF9, 8'h02, 4'd8, 8'h7C, 0);
        op8("remu",    3'd7, 8'hF9, 8'h02, 4'd9, 8'h01, 0);
        op8("divu_z",  3'd5, 8'd13,  8'h00, 4'd10, 8'hFF, 0);
        op8("remu_z",  3'd7, 8'd13,  8'h00, 4'd11, 8'd13, 0);
        op8("div_z",   3'd4, 8'hF3, 8'h00, 4'd12, 8'hFF, 0);
        op8("rem_z",   3'd6, 8'hF3, 8'h00, 4'd13, 8'hF3, 0);
        op8("div_ovf", 3'd4, 8'h80, 8'hFF, 4'd14, 8'h80, 0);
        op8("rem_ovf", 3'd6, 8'h80, 8'hFF, 4'd15, 8'h00, 0);
        op8("rem_neg", 3'd6, 8'h07, 8'hFE, 4'd1, 8'h01, 0);

        for (int i = 0; i < 300; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 8'h00;
                1: begin ra = 8'h80; rb = 8'hFF; end
                2: ra = 8'h80;
                default: ;
            endcase
            op8("rand", rop, ra, rb, 4'(i), ref8(rop, ra, rb), int'($urandom_range(0, 3)));
        end

        // Back-pressure then back-to-back accept on consume
        @(negedge clk);
        b_vld = 1'b1; b_op = 3'd0; b_a = 32'd123456; b_b = 32'd789; b_tag = 4'd5;
        @(posedge clk); #1;
        b_vld = 1'b0;
        wait32("bp_mul", n);
        chk_eq("bp_mul", 64'(b_res), 64'd97406784);
        repeat (5) begin
            @(negedge clk);
            chk_eq("bp_hold_res", 64'(b_res), 64'd97406784);
            chk_eq("bp_hold_tag", 64'(b_otag), 64'd5);
            chk_eq("bp_hold_rdy", 64'(b_rdy), 64'd0);
        end
        @(negedge clk);
        b_ordy = 1'b1; b_vld = 1'b1; b_op = 3'd5; b_a = 32'd1000; b_b = 32'd7; b_tag = 4'd9;
        #1;
        chk_eq("b2b_rdy", 64'(b_rdy), 64'd1);
        @(posedge clk); #1;
        b_vld = 1'b0; b_ordy = 1'b0;
        chk_eq("b2b_consumed", 64'(b_ovld), 64'd0);
        wait32("b2b_divu", n);
        chk_eq("b2b_divu", 64'(b_res), 64'd142);
        chk_eq("b2b_tag", 64'(b_otag), 64'd9);
        @(negedge clk);
        b_ordy = 1'b1;
        @(posedge clk); #1;
        b_ordy = 1'b0;

        // Flush at BUSY counter 10
        @(negedge clk);
        b_vld = 1'b1; b_op = 3'd0; b_a = 32'd7; b_b = 32'd9; b_tag = 4'd3;
        @(posedge clk); #1;
        b_vld = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk_eq("flush_ovld", 64'(b_ovld), 64'd0);
        chk_eq("flush_rdy", 64'(b_rdy), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (b_ovld) seen = 1'b1;
        end
        chk_eq("flush_no_result", 64'(seen), 64'd0);

        // Flush concurrent with a request
        @(negedge clk);
        b_vld = 1'b1; flush = 1'b1; b_tag = 4'd4;
        @(posedge clk); #1;
        b_vld = 1'b0; flush = 1'b0;
        chk_eq("flush_acc_rdy", 64'(b_rdy), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (b_ovld) seen = 1'b1;
        end
        chk_eq("flush_no_accept", 64'(seen), 64'd0);

        // Reset while holding a result
        @(negedge clk);
        b_vld = 1'b1; b_op = 3'd3; b_a = 32'hFFFF_FFFF; b_b = 32'd2; b_tag = 4'd6;
        @(posedge clk); #1;
        b_vld = 1'b0;
        wait32("rst_mulhu", n);
        chk_eq("rst_mulhu", 64'(b_res), 64'd1);
        chk_eq("rst_mulhu_tag", 64'(b_otag), 64'd6);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_eq("rst_done_ovld", 64'(b_ovld), 64'd0);
        chk_eq("rst_done_res", 64'(b_res), 64'd0);
        chk_eq("rst_done_tag", 64'(b_otag), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
